lcd_refresh: RTL

//  Shadow text buffer and refresh sequencer that sits directly upstream of the LCD controller (bus slave, regs 0x00-0x22).
//  CPU writes characters into a 2x16 shadow RAM at full bus speed; the sequencer streams them to the LCD controller.
//  Per row it sends: DDRAM address command, then 16 data writes. It polls controller busy between transfers.

---
 rtl/lcd_pkg.sv | 25 ++
 rtl/lcd_shadow_ram.sv | 26 ++
 rtl/lcd_refresh.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD refresh sequencer: FSM states, controller register map,
// and the DDRAM set-address command encoding.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_CHAR,
        ST_POLL_RD,
        ST_POLL_CHK,
        ST_SETTLE
    } lcd_state_e;

    localparam logic [5:0] LCD_REG_CTRL   = 6'h20;
    localparam logic [5:0] LCD_REG_CMD    = 6'h21;
    localparam logic [7:0] LCD_CMD_DDRAM  = 8'h80;
    localparam logic [7:0] LCD_ROW_STRIDE = 8'h40;
    localparam int         LCD_BUSY_HI    = 9;
    localparam int         LCD_BUSY_LO    = 8;

    function automatic logic [7:0] ddram_base(input logic [7:0] row);
        return LCD_CMD_DDRAM | 8'(row * LCD_ROW_STRIDE);
    endfunction

endpackage

// File: rtl/lcd_shadow_ram.sv
// Shadow character store: CPU read/write port plus a read-only sequencer port, both with
// one-cycle registered read latency. Contents are deliberately not reset.
module lcd_shadow_ram #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_cpu_we,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [7:0]    i_cpu_wdat,
    output logic [7:0]    o_cpu_rdat,
    input  logic [AW-1:0] i_seq_addr,
    output logic [7:0]    o_seq_rdat
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_cpu_we) begin
            r_mem[i_cpu_addr] <= i_cpu_wdat;
        end
        o_cpu_rdat <= r_mem[i_cpu_addr];
        o_seq_rdat <= r_mem[i_seq_addr];
    end

endmodule

// File: rtl/lcd_refresh.sv
// Shadow text buffer + refresh sequencer streaming rows to the LCD controller; CPU never stalls, request->first
// lcd_write 2 clocks, controller busy polled every 2 clocks. LCD_AUTO_REFRESH_EN: RAM writes also request a pass.
module lcd_refresh
    import lcd_pkg::*;
#(
    parameter int COLS          = 16,
    parameter int ROWS          = 2,
    parameter int SETTLE_CYCLES = 2000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_read,
    input  logic        i_write,
    input  logic [5:0]  i_address,
    input  logic [31:0] i_writedata,
    input  logic [3:0]  i_be,
    output logic [31:0] o_readdata,
    output logic        o_lcd_read,
    output logic        o_lcd_write,
    output logic [5:0]  o_lcd_address,
    output logic [31:0] o_lcd_writedata,
    input  logic [31:0] i_lcd_readdata
);

    localparam int DEPTH = COLS * ROWS;
    localparam int PW    = $clog2(DEPTH);
    localparam int CB    = $clog2(COLS);
    localparam int CW    = $clog2(SETTLE_CYCLES) + 1;

    lcd_state_e    r_state, w_state_nxt;
    logic [PW-1:0] r_pos, w_pos_nxt;
    logic [CW-1:0] r_cnt;
    logic          r_last_cmd, r_dirty, r_pending;
    logic [5:0]    r_lcd_address, w_lcd_address;
    logic [7:0]    r_lcd_wdat, w_lcd_wdat;
    logic          r_rd_ram, r_rd_ctrl;
    logic [2:0]    r_rd_stat;
    logic [7:0]    w_cpu_rdat, w_seq_rdat;
    logic          w_in_ram, w_ram_we, w_ctl_req, w_req, w_start;
    logic          w_unused;

    assign w_in_ram  = i_address < 6'(DEPTH);
    assign w_ram_we  = i_write && w_in_ram && i_be[0];
    assign w_ctl_req = i_write && (i_address == LCD_REG_CTRL) && i_writedata[0];
`ifdef LCD_AUTO_REFRESH_EN
    assign w_req     = w_ctl_req || w_ram_we;
`else
    assign w_req     = w_ctl_req;
`endif
    assign w_start   = (r_state == ST_IDLE) && r_pending;
    assign w_unused  = ^{i_be[3:1], i_writedata[31:8], i_lcd_readdata[31:10], i_lcd_readdata[7:0]};

    // Sequencer port is addressed with next-cycle pos so ram[pos] is already prefetched on entry to CHAR.
    lcd_shadow_ram #(.DEPTH(DEPTH)) u_ram (
        .i_clk      (i_clk),
        .i_cpu_we   (w_ram_we),
        .i_cpu_addr (i_address[PW-1:0]),
        .i_cpu_wdat (i_writedata[7:0]),
        .o_cpu_rdat (w_cpu_rdat),
        .i_seq_addr (w_pos_nxt),
        .o_seq_rdat (w_seq_rdat)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pos_nxt   = r_pos;
        case (r_state)
            ST_IDLE: begin
                if (r_pending) begin
                    w_state_nxt = ST_CMD;
                    w_pos_nxt   = '0;
                end
            end
            ST_CMD, ST_CHAR: w_state_nxt = ST_POLL_RD;
            ST_POLL_RD:      w_state_nxt = ST_POLL_CHK;
            ST_POLL_CHK: begin
                w_state_nxt = (i_lcd_readdata[LCD_BUSY_HI:LCD_BUSY_LO] != 2'b00) ? ST_POLL_RD : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (r_cnt == CW'(SETTLE_CYCLES - 1)) begin
                    if (r_last_cmd) begin
                        w_state_nxt = ST_CHAR;
                    end else if (r_pos == PW'(DEPTH - 1)) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_pos_nxt   = r_pos + PW'(1);
                        w_state_nxt = (r_pos[CB-1:0] == '1) ? ST_CMD : ST_CHAR;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Address/data are live during a strobe and otherwise hold the last strobed values.
    always_comb begin
        w_lcd_address = r_lcd_address;
        w_lcd_wdat    = r_lcd_wdat;
        case (r_state)
            ST_CMD: begin
                w_lcd_address = LCD_REG_CMD;
                w_lcd_wdat    = ddram_base(8'(r_pos[PW-1:CB]));
            end
            ST_CHAR: begin
                w_lcd_address = 6'(r_pos);
                w_lcd_wdat    = w_seq_rdat;
            end
            ST_POLL_RD: w_lcd_address = LCD_REG_CTRL;
            default: ;
        endcase
    end

    assign o_lcd_write     = (r_state == ST_CMD) || (r_state == ST_CHAR);
    assign o_lcd_read      = (r_state == ST_POLL_RD);
    assign o_lcd_address   = w_lcd_address;
    assign o_lcd_writedata = {24'h0, w_lcd_wdat};
    assign o_readdata      = r_rd_ram  ? {24'h0, w_cpu_rdat} :
                             r_rd_ctrl ? {29'h0, r_rd_stat}  : 32'h0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_pos         <= '0;
            r_cnt         <= '0;
            r_last_cmd    <= 1'b0;
            r_dirty       <= 1'b0;
            r_pending     <= 1'b0;
            r_lcd_address <= '0;
            r_lcd_wdat    <= '0;
            r_rd_ram      <= 1'b0;
            r_rd_ctrl     <= 1'b0;
            r_rd_stat     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pos   <= w_pos_nxt;
            r_cnt   <= (r_state == ST_SETTLE) ? r_cnt + CW'(1) : '0;
            if (r_state == ST_CMD) begin
                r_last_cmd <= 1'b1;
            end else if (r_state == ST_CHAR) begin
                r_last_cmd <= 1'b0;
            end
            if (o_lcd_write || o_lcd_read) begin
                r_lcd_address <= w_lcd_address;
                r_lcd_wdat    <= w_lcd_wdat;
            end
            // A new request or edit landing on the start cycle wins, so it is served by a later pass.
            r_pending <= w_req    || (r_pending && !w_start);
            r_dirty   <= w_ram_we || (r_dirty   && !w_start);
            r_rd_ram  <= i_read && w_in_ram;
            r_rd_ctrl <= i_read && (i_address == LCD_REG_CTRL);
            if (i_read) begin
                r_rd_stat <= {r_dirty, r_pending, r_state != ST_IDLE};
            end
        end
    end

endmodule
